// File: rtl/cpu_trace_checker_if.sv
// Trace-port bundle between the character source (master) and the trace checker (slave).
interface cpu_trace_checker_if #(
  parameter int TIME_W = 14,
  parameter int CNT_W  = 16
);
  logic [7:0]        char;
  logic [1:0]        format_type;
  logic [2:0]        error_code;
  logic [TIME_W-1:0] time_val;
  logic [31:0]       pc_val;
  logic [31:0]       dest_val;
  logic [31:0]       data_val;
  logic [CNT_W-1:0]  line_count;

  modport master (
    output char,
    input  format_type, error_code, time_val, pc_val, dest_val, data_val, line_count
  );

  modport slave (
    input  char,
    output format_type, error_code, time_val, pc_val, dest_val, data_val, line_count
  );
endinterface

// File: rtl/cpu_trace_checker.sv
// Streaming parser for register/memory write trace lines, one ASCII char per clock,
// with captured field values, legality flags and a completed-line counter.
module cpu_trace_checker #(
  parameter int          TIME_DIGITS = 4,
  parameter int          GRF_DIGITS  = 4,
  parameter int          TIME_W      = 14,
  parameter int          UPPER_HEX   = 0,
  parameter logic [31:0] PC_MIN      = 32'h3000,
  parameter logic [31:0] PC_MAX      = 32'h6ffc,
  parameter logic [31:0] ADDR_MAX    = 32'h2ffc,
  parameter int          CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  cpu_trace_checker_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_AT, S_PC, S_COLON_SP, S_GRF, S_ADDR,
    S_PRE_LT, S_EQ, S_PRE_DATA, S_DATA, S_DONE
  } state_t;

  localparam int MAX_TG     = (TIME_DIGITS > GRF_DIGITS) ? TIME_DIGITS : GRF_DIGITS;
  localparam int MAX_DIGITS = (MAX_TG > 8) ? MAX_TG : 8;
  localparam int DCW        = $clog2(MAX_DIGITS + 1);
  localparam logic [DCW-1:0] TIME_LIM = DCW'(TIME_DIGITS);
  localparam logic [DCW-1:0] GRF_LIM  = DCW'(GRF_DIGITS);
  localparam logic [DCW-1:0] HEX_LIM  = DCW'(8);

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;

  state_t            state_q;
  logic [DCW-1:0]    digits_q;
  logic [TIME_W-1:0] time_acc_q, time_val_q;
  logic [31:0]       pc_acc_q, dest_acc_q, data_acc_q;
  logic [31:0]       pc_val_q, dest_val_q, data_val_q;
  logic              is_mem_q;
  logic [1:0]        format_q;
  logic [2:0]        error_q;
  logic [CNT_W-1:0]  line_count_q;

  logic [7:0]        c;
  logic              is_dec_d, is_hex_d;
  logic [3:0]        nib_d;
  logic [TIME_W-1:0] time_next_d;
  logic [31:0]       grf_next_d;
  logic              pc_err_d, addr_err_d, grf_err_d;

  assign c = bus.char;

  // Letters share the low nibble layout: 'a'/'A' end in 1, so +9 gives 10.
  always_comb begin
    is_dec_d = (c >= 8'h30) && (c <= 8'h39);
    is_hex_d = is_dec_d;
    nib_d    = c[3:0];
    if (c >= 8'h61 && c <= 8'h66) begin
      is_hex_d = 1'b1;
      nib_d    = c[3:0] + 4'd9;
    end else if (UPPER_HEX != 0 && c >= 8'h41 && c <= 8'h46) begin
      is_hex_d = 1'b1;
      nib_d    = c[3:0] + 4'd9;
    end
  end

  assign time_next_d = time_acc_q * TIME_W'(10) + TIME_W'(nib_d);
  assign grf_next_d  = dest_acc_q * 32'd10 + 32'(nib_d);
  assign pc_err_d    = (pc_acc_q < PC_MIN) || (pc_acc_q > PC_MAX) || (pc_acc_q[1:0] != 2'b00);
  assign addr_err_d  = is_mem_q && ((dest_acc_q > ADDR_MAX) || (dest_acc_q[1:0] != 2'b00));
  assign grf_err_d   = !is_mem_q && (dest_acc_q > 32'd31);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      digits_q     <= '0;
      time_acc_q   <= '0;
      pc_acc_q     <= '0;
      dest_acc_q   <= '0;
      data_acc_q   <= '0;
      is_mem_q     <= 1'b0;
      time_val_q   <= '0;
      pc_val_q     <= '0;
      dest_val_q   <= '0;
      data_val_q   <= '0;
      format_q     <= 2'd0;
      error_q      <= 3'd0;
      line_count_q <= '0;
    end else begin
      format_q <= 2'd0;
      error_q  <= 3'd0;
      if (c == CH_CARET) begin
        state_q    <= S_TIME;
        digits_q   <= '0;
        time_acc_q <= '0;
        pc_acc_q   <= '0;
        dest_acc_q <= '0;
        data_acc_q <= '0;
        is_mem_q   <= 1'b0;
      end else begin
        // Anything not explicitly accepted below drops the partial line.
        state_q <= S_IDLE;
        case (state_q)
          S_TIME: begin
            if (is_dec_d && digits_q < TIME_LIM) begin
              state_q    <= S_TIME;
              time_acc_q <= time_next_d;
              digits_q   <= digits_q + 1'b1;
            end else if (c == CH_AT && digits_q != '0) begin
              state_q <= S_AT;
            end
          end
          S_AT: begin
            if (is_hex_d) begin
              state_q  <= S_PC;
              pc_acc_q <= {28'd0, nib_d};
              digits_q <= DCW'(1);
            end
          end
          S_PC: begin
            if (is_hex_d && digits_q < HEX_LIM) begin
              state_q  <= S_PC;
              pc_acc_q <= {pc_acc_q[27:0], nib_d};
              digits_q <= digits_q + 1'b1;
            end else if (c == CH_COLON && digits_q == HEX_LIM) begin
              state_q <= S_COLON_SP;
            end
          end
          S_COLON_SP: begin
            if (c == CH_SP) begin
              state_q <= S_COLON_SP;
            end else if (c == CH_DOLLAR) begin
              state_q  <= S_GRF;
              digits_q <= '0;
              is_mem_q <= 1'b0;
            end else if (c == CH_STAR) begin
              state_q  <= S_ADDR;
              digits_q <= '0;
              is_mem_q <= 1'b1;
            end
          end
          S_GRF: begin
            if (is_dec_d && digits_q < GRF_LIM) begin
              state_q    <= S_GRF;
              dest_acc_q <= grf_next_d;
              digits_q   <= digits_q + 1'b1;
            end else if (c == CH_SP && digits_q != '0) begin
              state_q <= S_PRE_LT;
            end else if (c == CH_LT && digits_q != '0) begin
              state_q <= S_EQ;
            end
          end
          S_ADDR: begin
            if (is_hex_d && digits_q < HEX_LIM) begin
              state_q    <= S_ADDR;
              dest_acc_q <= {dest_acc_q[27:0], nib_d};
              digits_q   <= digits_q + 1'b1;
            end else if (c == CH_SP && digits_q == HEX_LIM) begin
              state_q <= S_PRE_LT;
            end else if (c == CH_LT && digits_q == HEX_LIM) begin
              state_q <= S_EQ;
            end
          end
          S_PRE_LT: begin
            if (c == CH_SP)      state_q <= S_PRE_LT;
            else if (c == CH_LT) state_q <= S_EQ;
          end
          S_EQ: begin
            if (c == CH_EQ) state_q <= S_PRE_DATA;
          end
          S_PRE_DATA: begin
            if (c == CH_SP) begin
              state_q <= S_PRE_DATA;
            end else if (is_hex_d) begin
              state_q    <= S_DATA;
              data_acc_q <= {28'd0, nib_d};
              digits_q   <= DCW'(1);
            end
          end
          S_DATA: begin
            if (is_hex_d && digits_q < HEX_LIM) begin
              state_q    <= S_DATA;
              data_acc_q <= {data_acc_q[27:0], nib_d};
              digits_q   <= digits_q + 1'b1;
            end else if (c == CH_HASH && digits_q == HEX_LIM) begin
              state_q      <= S_DONE;
              format_q     <= is_mem_q ? 2'd2 : 2'd1;
              error_q      <= {grf_err_d, addr_err_d, pc_err_d};
              time_val_q   <= time_acc_q;
              pc_val_q     <= pc_acc_q;
              dest_val_q   <= dest_acc_q;
              data_val_q   <= data_acc_q;
              line_count_q <= line_count_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.format_type = format_q;
  assign bus.error_code  = error_q;
  assign bus.time_val    = time_val_q;
  assign bus.pc_val      = pc_val_q;
  assign bus.dest_val    = dest_val_q;
  assign bus.data_val    = data_val_q;
  assign bus.line_count  = line_count_q;
endmodule

// File: tb/tb_cpu_trace_checker.sv
// Randomized bench: builds trace lines as text, predicts each line's report from its fields.
module tb_cpu_trace_checker;
  logic clk = 1'b0;
  logic reset;

  cpu_trace_checker_if #(.TIME_W(14), .CNT_W(16)) bus();

  cpu_trace_checker #(
    .TIME_DIGITS(4), .GRF_DIGITS(4), .TIME_W(14), .UPPER_HEX(0),
    .PC_MIN(32'h3000), .PC_MAX(32'h6ffc), .ADDR_MAX(32'h2ffc), .CNT_W(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: what the outputs should currently hold.
  logic [15:0] cnt_m;
  logic [13:0] t_m;
  logic [31:0] pc_m, dst_m, dat_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input byte ch);
    bus.char = ch;
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag);
    chk({tag, ".time"},  64'(bus.time_val),   64'(t_m));
    chk({tag, ".pc"},    64'(bus.pc_val),     64'(pc_m));
    chk({tag, ".dest"},  64'(bus.dest_val),   64'(dst_m));
    chk({tag, ".data"},  64'(bus.data_val),   64'(dat_m));
    chk({tag, ".count"}, 64'(bus.line_count), 64'(cnt_m));
  endtask

  task automatic clear_model();
    cnt_m = '0; t_m = '0; pc_m = '0; dst_m = '0; dat_m = '0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.char = 8'h5E;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    chk("rst.ft_err", 64'({bus.format_type, bus.error_code}), 64'd0);
    check_held("rst");
    $display("tx reset");
  endtask

  task automatic run_line(input string s, input bit ok, input logic [1:0] ft, input logic [2:0] err,
                          input int unsigned tv, input logic [31:0] pc, input logic [31:0] dst,
                          input logic [31:0] dat);
    for (int i = 0; i < s.len(); i++) begin
      bit last;
      last = ok && (i == s.len() - 1);
      send(s[i]);
      if (last) begin
        cnt_m = cnt_m + 16'd1;
        t_m   = 14'(tv % 16384);
        pc_m  = pc;
        dst_m = dst;
        dat_m = dat;
      end
      chk("ft_err", 64'({bus.format_type, bus.error_code}), last ? 64'({ft, err}) : 64'd0);
    end
    check_held("line");
    $display("tx \"%s\" -> format=%0d err=%0d count=%0d", s, bus.format_type, bus.error_code,
             bus.line_count);
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      send($urandom_range(0, 1) ? 8'h78 : 8'h0A);
      chk("gap.ft_err", 64'({bus.format_type, bus.error_code}), 64'd0);
    end
  endtask

  function automatic string sp(input int n);
    string r;
    r = "";
    for (int i = 0; i < n; i++) r = {r, " "};
    return r;
  endfunction

  task automatic gen_line();
    int kind, pos;
    int unsigned tv;
    bit mem, ok;
    logic [31:0] pc, dst, dat;
    logic [2:0] err;
    logic [1:0] ft;
    string ts, ps, ds, dd, s;
    kind = $urandom_range(0, 11);
    mem  = 1'($urandom_range(0, 1));
    tv   = $urandom_range(0, 9999);
    if ($urandom_range(0, 1) != 0) pc = 32'h3000 + ($urandom_range(0, 32'hfff) << 2);
    else                           pc = $urandom_range(32'h2f00, 32'h7100);
    if (mem) begin
      if ($urandom_range(0, 1) != 0) dst = $urandom_range(0, 32'hbff) << 2;
      else                           dst = $urandom_range(0, 32'h3100);
    end else begin
      dst = $urandom_range(0, 40);
    end
    dat = $urandom;
    ts = $sformatf("%0d", tv);
    if (ts.len() < 4 && $urandom_range(0, 1) != 0) ts = {"0", ts};
    ps = $sformatf("%h", pc);
    if (mem) begin
      ds = {"*", $sformatf("%h", dst)};
    end else begin
      ds = $sformatf("%0d", dst);
      if (ds.len() < 4 && $urandom_range(0, 1) != 0) ds = {"0", ds};
      ds = {"$", ds};
    end
    dd = $sformatf("%h", dat);
    ok = 1'b1;
    case (kind)
      1: begin ts = $sformatf("%0d", tv); while (ts.len() < 5) ts = {"0", ts}; ok = 1'b0; end
      2: begin ps = {ps.substr(0, 2), ps.substr(4, 7)}; ok = 1'b0; end
      3: begin dat = dat | 32'hA; dd = $sformatf("%h", dat); dd = dd.toupper(); ok = 1'b0; end
      4: begin ts = ""; ok = 1'b0; end
      5: begin
        if (mem) begin
          ds = {"*0", $sformatf("%h", dst)};
        end else begin
          ds = $sformatf("%0d", dst);
          while (ds.len() < 5) ds = {"0", ds};
          ds = {"$", ds};
        end
        ok = 1'b0;
      end
      default: ;
    endcase
    s = {"^", ts, "@", ps, ":", sp($urandom_range(0, 2)), ds, sp($urandom_range(0, 2)),
         "<=", sp($urandom_range(0, 2)), dd, "#"};
    if (kind == 6) begin
      s  = s.substr(0, $urandom_range(0, s.len() - 2));
      ok = 1'b0;
    end else if (kind == 7) begin
      pos = $urandom_range(1, s.len() - 1);
      s   = {s.substr(0, pos - 1), "g", s.substr(pos, s.len() - 1)};
      ok  = 1'b0;
    end
    err[0] = (pc < 32'h3000) || (pc > 32'h6ffc) || (pc % 4 != 0);
    err[1] = mem && ((dst > 32'h2ffc) || (dst % 4 != 0));
    err[2] = !mem && (dst > 31);
    ft     = mem ? 2'd2 : 2'd1;
    run_line(s, ok, ft, err, tv, pc, dst, dat);
    gap();
  endtask

  initial begin
    reset    = 1'b1;
    bus.char = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_line("^12@00003004: $5 <= 0000000a#", 1'b1, 2'd1, 3'b000, 12, 32'h3004, 32'd5, 32'ha);
    send(8'h0A);
    chk("after.ft", 64'(bus.format_type), 64'd0);
    run_line("^999@00003010:*00000040<=   ffffffff#", 1'b1, 2'd2, 3'b000, 999, 32'h3010,
             32'h40, 32'hffffffff);
    run_line("^7@00002ffe: $40 <= 00000001#", 1'b1, 2'd1, 3'b101, 7, 32'h2ffe, 32'd40, 32'd1);
    run_line("^12345@00003000: $1 <= 00000001#", 1'b0, 2'd0, 3'd0, 0, 0, 0, 0);
    run_line("^1@0003000: $1 <= 00000001#", 1'b0, 2'd0, 3'd0, 0, 0, 0, 0);
    run_line("^1@00^2@00003000: $1<=00000001#", 1'b1, 2'd1, 3'b000, 2, 32'h3000, 32'd1, 32'd1);
    run_line("^5@00003000: $1 <= 0000ABCD#", 1'b0, 2'd0, 3'd0, 0, 0, 0, 0);
    run_line("^8@00007000: *00003000 <= 00000002#", 1'b1, 2'd2, 3'b011, 8, 32'h7000,
             32'h3000, 32'd2);

    run_line("^1@0000", 1'b0, 2'd0, 3'd0, 0, 0, 0, 0);
    do_reset();
    run_line("3000: $1 <= 00000001#", 1'b0, 2'd0, 3'd0, 0, 0, 0, 0);
    run_line("^3@00003000: $1 <= 00000001#", 1'b1, 2'd1, 3'b000, 3, 32'h3000, 32'd1, 32'd1);

    for (int n = 0; n < 300; n++) gen_line();
    send(8'h0A);
    chk("final.ft_err", 64'({bus.format_type, bus.error_code}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
